multi_debounce: RTL and testbench

Parametrised N-channel push-button conditioner, successor to the single-button debouncer. Each channel synchronises a raw button input, filters bounce with a per-channel stability counter and state machine, and emits a clean level plus single-cycle rise and fall strobes. A shared LED stage drives `led_driver` either as a wrapping press counter for one selected channel or as per-channel toggle latches. Sits between the board buttons and the lab's LED/control logic.

---
 rtl/multi_debounce.sv | 164 ++++++++++++++++
 tb/tb_multi_debounce.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// N-channel push-button conditioner: two-flop synchroniser, stability filter
// and registered level/strobe outputs per channel, plus a shared LED stage.
//
// state   | meaning
// IDLE_LO | accepted level 0, waiting for a high sample
// WAIT_HI | counting consecutive high samples
// IDLE_HI | accepted level 1, waiting for a low sample
// WAIT_LO | counting consecutive low samples
module multi_debounce #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 250000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES),
  parameter int LED_W         = 4,
  parameter int MODE          = 0,
  parameter int CNT_SEL       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   btn,
  input  logic              clr,
  output logic [N_CH-1:0]   debounce,
  output logic [N_CH-1:0]   rise,
  output logic [N_CH-1:0]   fall,
  output logic [LED_W-1:0]  led_driver
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] rise_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             s;

    assign s = sync2_q[g];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        IDLE_LO: begin
          if (s) begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          // any opposite sample restarts the filter from scratch
          if (!s) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_TC) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
            deb_d   = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_TC) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
            deb_d   = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE_LO;
        cnt_q   <= '0;
        deb_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        deb_q   <= deb_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign debounce[g] = deb_q;
    assign rise_all[g] = rise_q;
    assign fall[g]     = fall_q;
  end

  assign rise = rise_all;

  // LED bits beyond the channel count see no rise and stay at 0
  logic [LED_W-1:0] rise_led;
  if (N_CH >= LED_W) begin : g_led_trunc
    assign rise_led = rise_all[LED_W-1:0];
  end else begin : g_led_pad
    assign rise_led = {{(LED_W-N_CH){1'b0}}, rise_all};
  end

  logic [LED_W-1:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (clr) begin
      led_d = '0;
    end else if (MODE == 0) begin
      if (rise_all[CNT_SEL]) led_d = led_q + LED_W'(1);
    end else begin
      led_d = led_q ^ rise_led;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_d;
  end

  assign led_driver = led_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: one counter-mode and one toggle-mode
// instance share stimulus; expected outputs are queued with their due cycle.
`timescale 1ns/100ps
module tb_multi_debounce;

  localparam int S_DEB0 = 0, S_RISE0 = 1, S_FALL0 = 2, S_LED0 = 3;
  localparam int S_DEB1 = 4, S_RISE1 = 5, S_FALL1 = 6, S_LED1 = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'h0;
  logic       clr = 1'b0;
  logic [3:0] deb0, rise0, fall0, led0;
  logic [3:0] deb1, rise1, fall1, led1;

  multi_debounce #(.N_CH(4), .STABLE_CYCLES(4), .LED_W(4), .MODE(0), .CNT_SEL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .clr(clr),
    .debounce(deb0), .rise(rise0), .fall(fall0), .led_driver(led0)
  );

  multi_debounce #(.N_CH(4), .STABLE_CYCLES(4), .LED_W(4), .MODE(1), .CNT_SEL(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .clr(clr),
    .debounce(deb1), .rise(rise1), .fall(fall1), .led_driver(led1)
  );

  always #1 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  function automatic logic [31:0] get_sig(int sel);
    case (sel)
      S_DEB0:  return {28'h0, deb0};
      S_RISE0: return {28'h0, rise0};
      S_FALL0: return {28'h0, fall0};
      S_LED0:  return {28'h0, led0};
      S_DEB1:  return {28'h0, deb1};
      S_RISE1: return {28'h0, rise1};
      S_FALL1: return {28'h0, fall1};
      default: return {28'h0, led1};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int d, int sel, logic [31:0] e, string tag);
    sb_t item;
    item.due = cyc + d;
    item.sel = sel;
    item.exp = e;
    item.tag = tag;
    sb_q.push_back(item);
  endtask

  task automatic tick();
    int i;
    @(posedge clk);
    #1;
    cyc++;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due == cyc) begin
        check(sb_q[i].tag, get_sig(sb_q[i].sel), sb_q[i].exp);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_all_zero(string tag);
    for (int s = 0; s < 8; s++) check(tag, get_sig(s), 32'h0);
  endtask

  task automatic press0(int k);
    btn[0] = 1'b1;
    push(5, S_RISE0, 32'h0, "wrap_rise_early");
    push(6, S_RISE0, 32'h1, "wrap_rise");
    push(7, S_LED0, k % 16, "wrap_led0");
    push(7, S_LED1, k % 2, "wrap_led1");
    repeat (7) tick();
    btn[0] = 1'b0;
    push(6, S_FALL0, 32'h1, "wrap_fall");
    repeat (7) tick();
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    repeat (2) tick();
    check_all_zero("post_reset_idle");

    // reset mid-filter, release with all buttons held
    btn = 4'hF;
    repeat (3) tick();
    rst_n = 1'b0;
    #0.1;
    check_all_zero("reset_mid_filter");
    tick();
    rst_n = 1'b1;
    push(5, S_DEB0, 32'h0, "rst_deb_edge5");
    push(5, S_RISE0, 32'h0, "rst_rise_edge5");
    push(6, S_DEB0, 32'hF, "rst_deb_edge6");
    push(6, S_RISE0, 32'hF, "rst_rise_edge6");
    push(6, S_RISE1, 32'hF, "rst_rise1_edge6");
    push(7, S_RISE0, 32'h0, "rst_rise_width");
    push(7, S_DEB0, 32'hF, "rst_deb_hold");
    push(7, S_LED0, 32'h1, "rst_led0");
    push(7, S_LED1, 32'hF, "rst_led1");
    repeat (8) tick();
    rst_n = 1'b0;
    #0.1;
    check_all_zero("reset_async_active");
    btn = 4'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // clean press and release on channel 0
    btn[0] = 1'b1;
    push(5, S_RISE0, 32'h0, "clean_rise_edge5");
    push(6, S_RISE0, 32'h1, "clean_rise_edge6");
    push(6, S_DEB0, 32'h1, "clean_deb");
    push(6, S_LED0, 32'h0, "clean_led_pre");
    push(7, S_RISE0, 32'h0, "clean_rise_width");
    push(7, S_LED0, 32'h1, "clean_led0");
    push(7, S_LED1, 32'h1, "clean_led1");
    repeat (10) tick();
    btn[0] = 1'b0;
    push(5, S_FALL0, 32'h0, "clean_fall_edge5");
    push(6, S_FALL0, 32'h1, "clean_fall_edge6");
    push(6, S_DEB0, 32'h0, "clean_deb_low");
    push(7, S_FALL0, 32'h0, "clean_fall_width");
    push(7, S_LED0, 32'h1, "clean_led_after_fall");
    repeat (10) tick();

    // bounce: 1 x2, 0 x2, 1 x1, then 0
    for (int d = 1; d <= 14; d++) push(d, S_RISE0, 32'h0, "bounce_no_rise");
    push(14, S_DEB0, 32'h0, "bounce_deb");
    push(14, S_LED0, 32'h1, "bounce_led");
    btn[0] = 1'b1; repeat (2) tick();
    btn[0] = 1'b0; repeat (2) tick();
    btn[0] = 1'b1; tick();
    btn[0] = 1'b0; repeat (10) tick();

    // glitch boundary: 3 edges rejected, 4 edges accepted
    for (int d = 1; d <= 12; d++) push(d, S_RISE0, 32'h0, "glitch3_no_rise");
    btn[0] = 1'b1; repeat (3) tick();
    btn[0] = 1'b0; repeat (10) tick();
    push(6, S_RISE0, 32'h1, "glitch4_rise");
    push(7, S_LED0, 32'h2, "glitch4_led0");
    push(7, S_LED1, 32'h0, "glitch4_led1");
    btn[0] = 1'b1; repeat (4) tick();
    btn[0] = 1'b0;
    push(6, S_FALL0, 32'h1, "glitch4_fall");
    repeat (10) tick();

    // clr coincident with a rise strobe wins; debounce unaffected
    btn[0] = 1'b1;
    push(6, S_RISE0, 32'h1, "clr_rise");
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_led0", {28'h0, led0}, 32'h0);
    check("clr_led1", {28'h0, led1}, 32'h0);
    check("clr_deb_kept", {28'h0, deb0}, 32'h1);
    btn[0] = 1'b0;
    repeat (8) tick();

    // wrap: 16 presses, 1..15 then 0
    for (int k = 1; k <= 16; k++) press0(k);

    // toggle mode: ch1 and ch2 together, then ch2 again
    btn = 4'b0110;
    push(5, S_RISE1, 32'h0, "tog_rise_edge5");
    push(6, S_RISE1, 32'h6, "tog_rise_both");
    push(6, S_DEB1, 32'h6, "tog_deb_both");
    push(7, S_LED1, 32'h6, "tog_led_first");
    push(7, S_LED0, 32'h0, "tog_led0_unsel");
    repeat (8) tick();
    btn = 4'b0000;
    push(6, S_FALL1, 32'h6, "tog_fall_both");
    repeat (8) tick();
    btn = 4'b0100;
    push(6, S_RISE1, 32'h4, "tog_rise_ch2");
    push(7, S_LED1, 32'h2, "tog_led_second");
    repeat (8) tick();
    btn = 4'b0000;
    repeat (8) tick();

    // independence: ch1 held, ch3 bouncing with runs of at most 2
    begin
      logic [11:0] b3;
      b3 = 12'b0000_0010_1101;
      push(5, S_RISE0, 32'h0, "indep_rise_edge5");
      push(6, S_RISE0, 32'h2, "indep_rise_edge6");
      push(6, S_DEB0, 32'h2, "indep_deb");
      push(7, S_RISE0, 32'h0, "indep_rise_width");
      push(7, S_LED1, 32'h0, "indep_led1");
      push(14, S_DEB0, 32'h2, "indep_deb_final");
      push(14, S_LED0, 32'h0, "indep_led0");
      for (int t = 0; t < 14; t++) begin
        btn = {(t < 12) ? b3[t] : 1'b0, 3'b010};
        tick();
      end
    end
    btn = 4'h0;
    repeat (10) tick();

    while (sb_q.size() > 0) begin
      check({"unconsumed_", sb_q[0].tag}, 32'h1, 32'h0);
      sb_q.delete(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
